// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences a PLL out of reset on the free-running
// reference clock. It pulses the PLL reset, waits for lock with a timeout,
// retries a bounded number of times, qualifies lock as stable, and only then
// releases a synchronous downstream reset. Losing lock in RUN re-sequences.
//
// Optional feature macro: PLL_SUP_LOSS_CNT_EN
//   When defined, adds loss_cnt[7:0], a saturating count of RUN exits caused
//   by loss of lock. Only rst clears it.
//
// Ports:
//   refclk      in   reference clock (sole clock)
//   rst         in   asynchronous active-high reset
//   pll_locked  in   PLL lock indicator, asynchronous to refclk
//   relock_req  in   single-cycle request to re-sequence the PLL
//   pll_rst     out  reset to the PLL, active-high
//   sys_rst     out  downstream reset, active-high, synchronous to refclk
//   ready       out  high only in RUN
//   fail        out  high only in FAIL
//   retry_cnt   out  failed attempts in the current sequence (saturates at 3)
//   loss_cnt    out  (PLL_SUP_LOSS_CNT_EN only) lock losses seen in RUN

module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
`ifdef PLL_SUP_LOSS_CNT_EN
  output logic [7:0] loss_cnt,
`endif
  output logic [1:0] retry_cnt
);

  localparam int unsigned RETRY_W = 2;
  localparam int unsigned SYNC_W  = 2;
  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  // Parameter sanity: the shared counter must hold every cycle parameter,
  // every cycle parameter must be at least one, and retries fit retry_cnt.
  if (CNT_W < 1 || CNT_W > 32 ||
      RST_PULSE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 ||
      64'(RST_PULSE_CYCLES) > CNT_MAX ||
      64'(LOCK_TIMEOUT_CYCLES) > CNT_MAX ||
      64'(LOCK_STABLE_CYCLES) > CNT_MAX ||
      MAX_RETRIES > 3) begin : g_bad_param
    $error("pll_lock_supervisor: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_SAT    = RETRY_W'(3);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [RETRY_W-1:0] retry_n;
  logic [SYNC_W-1:0]  sync_q;
  logic               locked_s;
  logic               loss_evt;
  logic               pll_rst_n, sys_rst_n, ready_n, fail_n;

  // Two-flop synchronizer for the asynchronous lock indicator.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_W-1];

  // State, counter and registered outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= S_RESET_PLL;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      retry_cnt <= retry_n;
      pll_rst   <= pll_rst_n;
      sys_rst   <= sys_rst_n;
      ready     <= ready_n;
      fail      <= fail_n;
    end
  end

  // Next-state, counter and retry logic; outputs decode from the next state
  // so they change on the same edge as the state register.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    retry_n   = retry_cnt;
    loss_evt  = 1'b0;

    if (relock_req) begin
      // Relock wins over everything, including restarting an active pulse.
      state_n = S_RESET_PLL;
      cnt_n   = '0;
      retry_n = '0;
    end else begin
      case (state)
        S_RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end

        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_n = S_STABLE;
            cnt_n   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt_n = '0;
            if (retry_cnt == RETRY_LIMIT) begin
              state_n = S_FAIL;
            end else begin
              state_n = S_RESET_PLL;
              if (retry_cnt != RETRY_SAT) begin
                retry_n = retry_cnt + RETRY_W'(1);
              end
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end

        S_STABLE: begin
          // A lock glitch here falls back to waiting without costing a retry.
          if (!locked_s) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_n = S_RUN;
            cnt_n   = '0;
            retry_n = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end

        S_RUN: begin
          if (!locked_s) begin
            state_n  = S_RESET_PLL;
            cnt_n    = '0;
            loss_evt = 1'b1;
          end
        end

        S_FAIL: begin
          // Parked until rst or relock_req.
        end

        default: begin
          state_n = S_RESET_PLL;
          cnt_n   = '0;
        end
      endcase
    end

    pll_rst_n = (state_n == S_RESET_PLL);
    sys_rst_n = (state_n != S_RUN);
    ready_n   = (state_n == S_RUN);
    fail_n    = (state_n == S_FAIL);
  end

`ifdef PLL_SUP_LOSS_CNT_EN
  // Saturating loss-of-lock counter; relock_req deliberately leaves it alone.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_cnt <= '0;
    end else if (loss_evt && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end
`else
  logic unused_loss_evt;
  assign unused_loss_evt = loss_evt;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor with small parameters
// (pulse 4, timeout 20, stable 8, max retries 2). The stimulus process
// queues hand-computed expectations tagged with the edge number they
// apply to; a monitor on the falling edge pops and compares them.

module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_rst, ready, fail;
  logic [1:0] retry_cnt;
`ifdef PLL_SUP_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2),
    .CNT_W              (16)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fail      (fail),
`ifdef PLL_SUP_LOSS_CNT_EN
    .loss_cnt  (loss_cnt),
`endif
    .retry_cnt (retry_cnt)
  );

  always #5 refclk = ~refclk;

  // Edge index: edge 0 is the first rising edge after rst is released.
  int ecount = -3;
  always @(posedge refclk) ecount <= ecount + 1;

  localparam int K_PLL_RST = 0;
  localparam int K_SYS_RST = 1;
  localparam int K_READY   = 2;
  localparam int K_FAIL    = 3;
  localparam int K_RETRY   = 4;
  localparam int K_LOSS    = 5;

  typedef struct {
    int         edge_n;
    int         kind;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [7:0] actual(input int kind);
    case (kind)
      K_PLL_RST: return {7'd0, pll_rst};
      K_SYS_RST: return {7'd0, sys_rst};
      K_READY:   return {7'd0, ready};
      K_FAIL:    return {7'd0, fail};
      K_RETRY:   return {6'd0, retry_cnt};
`ifdef PLL_SUP_LOSS_CNT_EN
      K_LOSS:    return loss_cnt;
`endif
      default:   return 8'hXX;
    endcase
  endfunction

  task automatic expect_at(input int e, input int kind, input int v, input string name);
    exp_t x;
    x.edge_n = e;
    x.kind   = kind;
    x.val    = 8'(v);
    x.name   = name;
    sb.push_back(x);
  endtask

  task automatic expect_all(input int e, input int pr, input int sr, input int rd,
                            input int fl, input int rc, input string tag);
    expect_at(e, K_PLL_RST, pr, {tag, ".pll_rst"});
    expect_at(e, K_SYS_RST, sr, {tag, ".sys_rst"});
    expect_at(e, K_READY,   rd, {tag, ".ready"});
    expect_at(e, K_FAIL,    fl, {tag, ".fail"});
    expect_at(e, K_RETRY,   rc, {tag, ".retry_cnt"});
  endtask

  task automatic expect_loss(input int e, input int v, input string name);
`ifdef PLL_SUP_LOSS_CNT_EN
    expect_at(e, K_LOSS, v, name);
`else
    if (e < -100 && v < 0) $display("unused %s", name);
`endif
  endtask

  // Returns 1 ns after edge k.
  task automatic wait_edge(input int k);
    while (ecount < k) begin
      @(posedge refclk);
      #1;
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare any queued
  // expectation that belongs to the current edge.
  exp_t       mx;
  logic [7:0] mact;
  always @(negedge refclk) begin
    while (sb.size() > 0 && sb[0].edge_n <= ecount) begin
      mx = sb.pop_front();
      vectors++;
      if (mx.edge_n < ecount) begin
        miscompares++;
        $display("FAIL %s: edge %0d not sampled (now %0d)", mx.name, mx.edge_n, ecount);
      end else begin
        mact = actual(mx.kind);
        if (mact !== mx.val) begin
          miscompares++;
          $display("FAIL %s @edge %0d: got %0d expected %0d", mx.name, mx.edge_n, mact, mx.val);
        end
      end
    end
  end

  initial begin
    // Reset values and clean lock.
    expect_all(-1, 1, 1, 0, 0, 0, "reset");
    expect_loss(-1, 0, "reset.loss_cnt");
    expect_at(0, K_PLL_RST, 1, "pulse.e0");
    expect_at(2, K_PLL_RST, 1, "pulse.e2");
    expect_at(3, K_PLL_RST, 0, "pulse.e3_low");
    expect_at(3, K_SYS_RST, 1, "wait.sys_rst");
    expect_at(16, K_READY, 0, "stable.e16_ready");
    expect_at(16, K_SYS_RST, 1, "stable.e16_sys_rst");
    expect_all(17, 0, 0, 1, 0, 0, "run.e17");

    #22 rst = 1'b0;
    wait_edge(6);
    pll_locked = 1'b1;

    // Relock from RUN, then a lock glitch while in STABLE.
    wait_edge(18);
    expect_all(20, 1, 1, 0, 0, 0, "relock.e20");
    expect_at(23, K_PLL_RST, 1, "relock.e23");
    expect_at(24, K_PLL_RST, 0, "relock.e24");
    expect_at(30, K_READY, 0, "glitch.e30");
    expect_all(31, 0, 1, 0, 0, 0, "glitch.e31");
    expect_at(33, K_READY, 0, "glitch.no_early_run");
    expect_at(41, K_READY, 0, "glitch.e41");
    expect_all(42, 0, 0, 1, 0, 0, "glitch.run_e42");
    wait_edge(19);
    relock_req = 1'b1;
    wait_edge(20);
    relock_req = 1'b0;
    wait_edge(28);
    pll_locked = 1'b0;
    wait_edge(31);
    pll_locked = 1'b1;

    // Loss in RUN, then no lock: three attempts and FAIL.
    wait_edge(43);
    expect_at(46, K_READY, 1, "loss.e46_ready");
    expect_loss(46, 0, "loss.e46_cnt");
    expect_all(47, 1, 1, 0, 0, 0, "loss.e47");
    expect_loss(47, 1, "loss.e47_cnt");
    expect_at(50, K_PLL_RST, 1, "loss.e50");
    expect_at(51, K_PLL_RST, 0, "loss.e51");
    expect_at(70, K_PLL_RST, 0, "nolock.e70");
    expect_at(70, K_RETRY, 0, "nolock.e70_retry");
    expect_at(71, K_PLL_RST, 1, "nolock.e71");
    expect_at(71, K_RETRY, 1, "nolock.e71_retry");
    expect_at(74, K_PLL_RST, 1, "nolock.e74");
    expect_at(75, K_PLL_RST, 0, "nolock.e75");
    expect_at(95, K_PLL_RST, 1, "nolock.e95");
    expect_at(95, K_RETRY, 2, "nolock.e95_retry");
    expect_at(118, K_FAIL, 0, "nolock.e118_fail");
    expect_all(119, 0, 1, 0, 1, 2, "fail.e119");
    expect_at(125, K_FAIL, 1, "fail.e125");
    expect_at(125, K_PLL_RST, 0, "fail.e125_pll_rst");
    expect_at(125, K_SYS_RST, 1, "fail.e125_sys_rst");
    wait_edge(44);
    pll_locked = 1'b0;

    // Recovery from FAIL via relock_req.
    wait_edge(126);
    expect_all(130, 1, 1, 0, 0, 0, "recover.e130");
    expect_at(133, K_PLL_RST, 1, "recover.e133");
    expect_loss(133, 1, "recover.loss_kept");
    expect_at(134, K_PLL_RST, 0, "recover.e134");
    wait_edge(129);
    relock_req = 1'b1;
    wait_edge(130);
    relock_req = 1'b0;

    // Asynchronous reset in the middle of WAIT_LOCK with retry_cnt=1.
    wait_edge(135);
    expect_at(159, K_PLL_RST, 0, "areset.e159");
    expect_at(159, K_RETRY, 1, "areset.e159_retry");
    expect_all(160, 1, 1, 0, 0, 0, "areset.e160");
    expect_loss(160, 0, "areset.loss_cnt");
    wait_edge(160);
    #2 rst = 1'b1;
    wait_edge(162);
    rst = 1'b0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge refclk);
    while (sb.size() > 0) begin
      mx = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: edge %0d never checked (got none, expected %0d)", mx.name, mx.edge_n, mx.val);
    end
    #10;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
